// File: rtl/ram_pkg.sv
// Shared definitions for the forwarding dual-port RAM: the fill-FSM state
// encoding and the ceil(log2) helper used to size addresses.
package ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Smallest r with 2**r >= n, never less than 1 so a 2-word RAM still has an address bit.
  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ram_array.sv
// Byte-enabled storage array: one write port, one synchronous read port,
// read-before-write on a same-address collision.
module ram_array #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int BE_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [BE_WIDTH-1:0]   wbe_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] wmask;

  // Each data bit follows the enable of the byte lane it sits in; the top lane may be partial.
  for (genvar b = 0; b < WIDTH; b++) begin : g_mask
    assign wmask[b] = wbe_i[b/8];
  end

  // NOTE: the storage has no reset; clearing is done by the zero-fill walk in the top,
  // which keeps this array mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= (mem[waddr_i] & ~wmask) | (wdata_i & wmask);
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/fwd_dual_port_ram.sv
// Dual-port RAM with zero-fill FSM, out-of-range handling and optional output register.
// Define DPRAM_WRITE_FORWARD_EN to forward same-edge write data into a colliding read.
module fwd_dual_port_ram
  import ram_pkg::*;
#(
  parameter int  WIDTH      = 32,
  parameter int  DEPTH      = 1024,
  parameter int  OUT_REG    = 0,
  localparam int ADDR_WIDTH = log2_ceil(DEPTH),
  localparam int BE_WIDTH   = (WIDTH + 7) / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output logic [WIDTH-1:0]      read_data,
  output logic                  read_valid,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [WIDTH-1:0]      write_data,
  input  logic [BE_WIDTH-1:0]   write_byte_enable,
  input  logic                  clear_req,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q;
  logic                  busy_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;

  logic                  rd_fire, wr_fire, rd_oob;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [WIDTH-1:0]      mem_wdata, mem_rdata, mem_word, rd_word;
  logic [BE_WIDTH-1:0]   mem_wbe;
  logic                  rd_vld_q, rd_oob_q;

  assign busy    = busy_q;
  assign rd_fire = read_en & ~busy_q;
  assign wr_fire = write_enable & ~busy_q & ({1'b0, write_address} < DEPTH_W);
  assign rd_oob  = {1'b0, read_address} >= DEPTH_W;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      busy_q    <= 1'b1;
      clr_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clear_req) begin
            state_q   <= ST_CLEAR;
            busy_q    <= 1'b1;
            clr_cnt_q <= '0;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_q == LAST_ADDR) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            clr_cnt_q <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // The fill owns the write port while busy; user writes are only possible when idle.
  always_comb begin
    mem_we    = (busy_q & ~rst) | wr_fire;
    mem_waddr = busy_q ? clr_cnt_q : write_address;
    mem_wdata = busy_q ? '0 : write_data;
    mem_wbe   = busy_q ? '1 : write_byte_enable;
  end

  ram_array #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .BE_WIDTH  (BE_WIDTH)
  ) u_array (
    .clk    (clk),
    .we_i   (mem_we),
    .waddr_i(mem_waddr),
    .wdata_i(mem_wdata),
    .wbe_i  (mem_wbe),
    .re_i   (rd_fire),
    .raddr_i(read_address),
    .rdata_o(mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_q <= 1'b0;
      rd_oob_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_fire;
      if (rd_fire) rd_oob_q <= rd_oob;
    end
  end

  assign mem_word = rd_oob_q ? '0 : mem_rdata;

`ifdef DPRAM_WRITE_FORWARD_EN
  logic             fwd_hit_q;
  logic [WIDTH-1:0] fwd_data_q, fwd_mask_q, wr_mask;

  for (genvar b = 0; b < WIDTH; b++) begin : g_fwd_mask
    assign wr_mask[b] = write_byte_enable[b/8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      fwd_mask_q <= '0;
    end else if (rd_fire) begin
      fwd_hit_q  <= wr_fire && (write_address == read_address);
      fwd_data_q <= write_data;
      fwd_mask_q <= wr_mask;
    end
  end

  assign rd_word = fwd_hit_q ? ((mem_word & ~fwd_mask_q) | (fwd_data_q & fwd_mask_q)) : mem_word;
`else
  assign rd_word = mem_word;
`endif

  if (OUT_REG != 0) begin : g_out_reg
    logic             out_vld_q;
    logic [WIDTH-1:0] out_data_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_vld_q  <= 1'b0;
        out_data_q <= '0;
      end else begin
        out_vld_q <= rd_vld_q;
        if (rd_vld_q) out_data_q <= rd_word;
      end
    end

    assign read_valid = out_vld_q;
    assign read_data  = out_data_q;
  end else begin : g_out_comb
    // Holds the last result so read_data stays stable between valid pulses.
    logic [WIDTH-1:0] hold_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) hold_q <= '0;
      else if (rd_vld_q) hold_q <= rd_word;
    end

    assign read_valid = rd_vld_q;
    assign read_data  = rd_vld_q ? rd_word : hold_q;
  end

endmodule
